// File: rtl/bsg_skid_buffer_areset_if.sv
// Valid/ready stream bundle for the two-entry skid buffer.
// The slave side is the buffer; the master side is its producer/consumer pair.
interface bsg_skid_buffer_areset_if #(
  parameter int unsigned width_p = 128
);
  logic               v_i;
  logic [width_p-1:0] data_i;
  logic               ready_o;
  logic               v_o;
  logic [width_p-1:0] data_o;
  logic               ready_i;
  logic [1:0]         count_o;

  modport slave (
    input  v_i,
    input  data_i,
    input  ready_i,
    output ready_o,
    output v_o,
    output data_o,
    output count_o
  );

  modport master (
    output v_i,
    output data_i,
    output ready_i,
    input  ready_o,
    input  v_o,
    input  data_o,
    input  count_o
  );
endinterface

// File: rtl/bsg_skid_buffer_areset.sv
// Two-entry registered skid buffer; every output comes straight from a flop,
// so ready_i/v_i/data_i never reach an output combinationally.
module bsg_skid_buffer_areset #(
  parameter int unsigned width_p = 128
) (
  input logic                      clk_i,
  input logic                      reset_i,
  bsg_skid_buffer_areset_if.slave  io
);

  // State encoding is literally {main_v, skid_v}.
  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    ILLEGAL = 2'b01,
    ONE     = 2'b10,
    FULL    = 2'b11
  } state_e;

  state_e             state_q, state_n;
  logic               main_v, skid_v;
  logic               in_fire, out_fire;
  logic               main_ld, main_from_skid, skid_ld;
  logic [width_p-1:0] main_r, skid_r;

  assign {main_v, skid_v} = state_q;

  assign io.v_o     = main_v;
  assign io.ready_o = ~skid_v;
  assign io.data_o  = main_r;
  assign io.count_o = {1'b0, main_v} + {1'b0, skid_v};

  assign in_fire  = io.v_i & ~skid_v;
  assign out_fire = main_v & io.ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= EMPTY;
    else         state_q <= state_n;
  end

  always_comb begin
    state_n        = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_ld = 1'b1;
          state_n = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_ld = 1'b1;
        end else if (in_fire) begin
          skid_ld = 1'b1;
          state_n = FULL;
        end else if (out_fire) begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        // ready_o is low here, so only a drain can happen.
        if (out_fire) begin
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
          state_n        = ONE;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      main_r <= '0;
      skid_r <= '0;
    end else begin
      if (main_ld) main_r <= main_from_skid ? skid_r : io.data_i;
      if (skid_ld) skid_r <= io.data_i;
    end
  end

endmodule

// File: tb/tb_bsg_skid_buffer_areset.sv
// Directed and randomized checks of the skid buffer at widths 128 and 1.
module tb_bsg_skid_buffer_areset;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  bsg_skid_buffer_areset_if #(.width_p(128)) ifa ();
  bsg_skid_buffer_areset_if #(.width_p(1))   ifb ();

  bsg_skid_buffer_areset #(.width_p(128)) dut_a (
    .clk_i   (clk),
    .reset_i (reset_i),
    .io      (ifa.slave)
  );

  bsg_skid_buffer_areset #(.width_p(1)) dut_b (
    .clk_i   (clk),
    .reset_i (reset_i),
    .io      (ifb.slave)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [127:0] a5;
    a5 = {16{8'hA5}};
    ifa.v_i = 0; ifa.ready_i = 0; ifa.data_i = '0;
    ifb.v_i = 0; ifb.ready_i = 0; ifb.data_i = '0;
    reset_i = 1;
    cyc(); cyc();
    total++; if (ifa.v_o !== 1'b0) begin bad++; $display("FAIL rst_v_o got=%b exp=0", ifa.v_o); end
    total++; if (ifa.data_o !== 128'h0) begin bad++; $display("FAIL rst_data_o got=%h exp=0", ifa.data_o); end
    total++; if (ifa.count_o !== 2'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", ifa.count_o); end
    total++; if (ifa.ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", ifa.ready_o); end
    reset_i = 0;
    ifa.v_i = 1; ifa.data_i = a5;
    cyc(); cyc();
    ifa.v_i = 0;
    total++; if (ifa.count_o !== 2'd2) begin bad++; $display("FAIL fill_count got=%0d exp=2", ifa.count_o); end
    total++; if (ifa.ready_o !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", ifa.ready_o); end
    total++; if (ifa.data_o !== a5) begin bad++; $display("FAIL fill_data got=%h exp=%h", ifa.data_o, a5); end
    // async assertion midway between edges
    #2 reset_i = 1;
    #1;
    total++; if (ifa.v_o !== 1'b0) begin bad++; $display("FAIL async_v_o got=%b exp=0", ifa.v_o); end
    total++; if (ifa.data_o !== 128'h0) begin bad++; $display("FAIL async_data got=%h exp=0", ifa.data_o); end
    total++; if (ifa.count_o !== 2'd0) begin bad++; $display("FAIL async_count got=%0d exp=0", ifa.count_o); end
    total++; if (ifa.ready_o !== 1'b1) begin bad++; $display("FAIL async_ready got=%b exp=1", ifa.ready_o); end
    cyc();
    reset_i = 0;
    ifa.v_i = 1; ifa.data_i = 128'h1; ifa.ready_i = 0;
    cyc();
    ifa.v_i = 0;
    total++; if (ifa.data_o !== 128'h1) begin bad++; $display("FAIL post_rst_data got=%h exp=1", ifa.data_o); end
    total++; if (ifa.count_o !== 2'd1) begin bad++; $display("FAIL post_rst_count got=%0d exp=1", ifa.count_o); end
    ifa.ready_i = 1;
    cyc();
    total++; if (ifa.count_o !== 2'd0) begin bad++; $display("FAIL post_rst_drain got=%0d exp=0", ifa.count_o); end
  endtask

  task automatic test_streaming();
    ifa.ready_i = 1;
    for (int i = 0; i < 16; i++) begin
      ifa.v_i = 1; ifa.data_i = 128'(i);
      cyc();
      total++; if (ifa.data_o !== 128'(i)) begin bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, ifa.data_o, 128'(i)); end
      total++; if (ifa.count_o !== 2'd1) begin bad++; $display("FAIL stream_count[%0d] got=%0d exp=1", i, ifa.count_o); end
      total++; if (ifa.ready_o !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, ifa.ready_o); end
    end
    ifa.v_i = 0;
    cyc();
    total++; if (ifa.count_o !== 2'd0) begin bad++; $display("FAIL stream_end got=%0d exp=0", ifa.count_o); end
  endtask

  task automatic test_back_pressure();
    ifa.ready_i = 0;
    ifa.v_i = 1; ifa.data_i = 128'h11;
    cyc();
    total++; if (ifa.count_o !== 2'd1) begin bad++; $display("FAIL bp_count1 got=%0d exp=1", ifa.count_o); end
    total++; if (ifa.ready_o !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b exp=1", ifa.ready_o); end
    ifa.data_i = 128'h22;
    cyc();
    total++; if (ifa.count_o !== 2'd2) begin bad++; $display("FAIL bp_count2 got=%0d exp=2", ifa.count_o); end
    total++; if (ifa.ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready2 got=%b exp=0", ifa.ready_o); end
    ifa.data_i = 128'h33;
    cyc();
    total++; if (ifa.count_o !== 2'd2) begin bad++; $display("FAIL bp_hold_count got=%0d exp=2", ifa.count_o); end
    total++; if (ifa.data_o !== 128'h11) begin bad++; $display("FAIL bp_out0 got=%h exp=11", ifa.data_o); end
    ifa.ready_i = 1;
    cyc();
    total++; if (ifa.data_o !== 128'h22) begin bad++; $display("FAIL bp_out1 got=%h exp=22", ifa.data_o); end
    total++; if (ifa.count_o !== 2'd1) begin bad++; $display("FAIL bp_count3 got=%0d exp=1", ifa.count_o); end
    cyc();
    ifa.v_i = 0;
    total++; if (ifa.data_o !== 128'h33) begin bad++; $display("FAIL bp_out2 got=%h exp=33", ifa.data_o); end
    total++; if (ifa.count_o !== 2'd1) begin bad++; $display("FAIL bp_count4 got=%0d exp=1", ifa.count_o); end
    cyc();
    total++; if (ifa.count_o !== 2'd0) begin bad++; $display("FAIL bp_empty got=%0d exp=0", ifa.count_o); end
  endtask

  task automatic test_full_drain();
    ifa.ready_i = 0;
    ifa.v_i = 1; ifa.data_i = 128'h11;
    cyc();
    ifa.data_i = 128'h22;
    cyc();
    ifa.v_i = 0;
    total++; if (ifa.count_o !== 2'd2) begin bad++; $display("FAIL drain_full got=%0d exp=2", ifa.count_o); end
    ifa.ready_i = 1;
    cyc();
    ifa.ready_i = 0;
    total++; if (ifa.data_o !== 128'h22) begin bad++; $display("FAIL drain_data got=%h exp=22", ifa.data_o); end
    total++; if (ifa.count_o !== 2'd1) begin bad++; $display("FAIL drain_count got=%0d exp=1", ifa.count_o); end
    total++; if (ifa.ready_o !== 1'b1) begin bad++; $display("FAIL drain_ready got=%b exp=1", ifa.ready_o); end
    cyc();
    total++; if (ifa.data_o !== 128'h22) begin bad++; $display("FAIL drain_hold got=%h exp=22", ifa.data_o); end
    ifa.ready_i = 1;
    cyc();
    ifa.ready_i = 0;
    total++; if (ifa.v_o !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", ifa.v_o); end
  endtask

  task automatic test_random();
    logic [127:0] q[$];
    logic [127:0] exp_d, prev_d;
    logic         prev_v, prev_out;
    for (int c = 0; c < 10000; c++) begin
      ifa.v_i     = 1'($urandom_range(1));
      ifa.ready_i = 1'($urandom_range(1));
      ifa.data_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
      prev_v   = ifa.v_o;
      prev_d   = ifa.data_o;
      prev_out = ifa.v_o & ifa.ready_i;
      if (prev_out) begin
        exp_d = (q.size() != 0) ? q.pop_front() : 128'hx;
        total++; if (ifa.data_o !== exp_d) begin bad++; $display("FAIL rnd_order[%0d] got=%h exp=%h", c, ifa.data_o, exp_d); end
      end
      if (ifa.v_i && ifa.ready_o) q.push_back(ifa.data_i);
      cyc();
      total++; if (ifa.count_o !== 2'(q.size())) begin bad++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", c, ifa.count_o, q.size()); end
      total++; if (ifa.count_o > 2'd2) begin bad++; $display("FAIL rnd_count_max[%0d] got=%0d exp<=2", c, ifa.count_o); end
      total++; if (ifa.ready_o !== (q.size() < 2)) begin bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", c, ifa.ready_o, q.size() < 2); end
      if (prev_v && !prev_out) begin
        total++; if (ifa.v_o !== 1'b1) begin bad++; $display("FAIL rnd_v_drop[%0d] got=%b exp=1", c, ifa.v_o); end
        total++; if (ifa.data_o !== prev_d) begin bad++; $display("FAIL rnd_stable[%0d] got=%h exp=%h", c, ifa.data_o, prev_d); end
      end
    end
    ifa.v_i = 0; ifa.ready_i = 1;
    cyc(); cyc(); cyc();
    ifa.ready_i = 0;
    total++; if (ifa.count_o !== 2'd0) begin bad++; $display("FAIL rnd_final got=%0d exp=0", ifa.count_o); end
  endtask

  task automatic test_width();
    logic [127:0] pats[5];
    logic [127:0] p;
    pats[0] = '1;
    pats[1] = {32{4'h5}};
    pats[2] = {32{4'hA}};
    pats[3] = {32{4'h5}};
    pats[4] = {32{4'hA}};
    ifa.ready_i = 1; ifb.ready_i = 1;
    for (int k = 0; k < 5; k++) begin
      p = pats[k];
      ifa.v_i = 1; ifa.data_i = p;
      ifb.v_i = 1; ifb.data_i = p[0];
      cyc();
      total++; if (ifa.data_o !== p) begin bad++; $display("FAIL width128[%0d] got=%h exp=%h", k, ifa.data_o, p); end
      total++; if (ifb.data_o !== p[0] || ifb.v_o !== 1'b1) begin bad++; $display("FAIL width1[%0d] got=%b/%b exp=%b/1", k, ifb.data_o, ifb.v_o, p[0]); end
    end
    ifa.v_i = 0; ifb.v_i = 0;
    cyc();
    total++; if (ifb.count_o !== 2'd0) begin bad++; $display("FAIL width1_empty got=%0d exp=0", ifb.count_o); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_full_drain();
    test_random();
    test_width();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_skid_buffer_areset.md
# bsg_skid_buffer_areset

Two-entry valid/ready skid buffer that registers a `width_p`-bit stream with no combinational path from `yumi`/`ready` back to the producer. It sits directly upstream of the team's reset-able output flop stage: it absorbs downstream back-pressure and presents a registered `v_o`/`data_o` pair that the following flop stage captures. All state clears asynchronously on reset.

## Interface
- `width_p`, default 128: data width in bits, ≥1.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_i`  in  1  reset, asynchronous and active-high; clears all state immediately on assertion and is released synchronously by the driver.
- `v_i`  in  1  producer data valid.
- `data_i`  in  `width_p`  producer data; sampled only on a handshake.
- `ready_o`  out  1  buffer can accept; driven directly from a flop.
- `v_o`  out  1  `data_o` is valid; driven directly from a flop.
- `data_o`  out  `width_p`  head data; driven directly from a flop.
- `ready_i`  in  1  consumer accepts `data_o` this cycle.
- `count_o`  out  2  occupancy, 0..2.

## Operation
- Input handshake: `in_fire = v_i & ready_o`.
- Output handshake: `out_fire = v_o & ready_i`.
- Storage: `main` register (drives `data_o`) and `skid` register, with valid bits `main_v` and `skid_v`.
- State machine, encoded by (`main_v`, `skid_v`):
  - **EMPTY (0,0)**
    - `in_fire` → `main <= data_i`; go to ONE.
    - Otherwise stay in EMPTY.
  - **ONE (1,0)**
    - `in_fire & out_fire` → `main <= data_i`; stay in ONE.
    - `in_fire` only → `skid <= data_i`; go to FULL.
    - `out_fire` only → go to EMPTY.
    - Neither → hold.
  - **FULL (1,1)**
    - `ready_o = 0`, so `in_fire` is impossible.
    - `out_fire` → `main <= skid`; go to ONE.
    - Otherwise hold.
- State (0,1) is illegal and unreachable. If it is ever entered, the next edge goes to EMPTY.
- Output derivation:
  - `v_o = main_v`.
  - `ready_o = ~skid_v`.
  - `count_o = main_v + skid_v`.
- Data registers load only on the transitions listed above and hold otherwise.
- Ordering is strictly FIFO. No data is dropped or duplicated.
- `data_i` is ignored when `v_i = 0` or `ready_o = 0`. `ready_i` is ignored when `v_o = 0`.
- No width conversion or arithmetic: data passes bit-exact.

## Timing
- Reset values, applied asynchronously while `reset_i = 1`:
  - `v_o = 0`
  - `data_o = 0`
  - `count_o = 0`
  - `ready_o = 1`
  - `skid` data = 0
- While `reset_i = 1`, handshakes are ignored and no register loads.
- Reset asserted mid-transfer (ONE or FULL) discards the held data. The first edge after release behaves as EMPTY.
- Latency: a word accepted at edge N appears on `data_o` with `v_o = 1` after edge N, i.e. one cycle. A word held in skid reaches `data_o` one cycle after the `out_fire` that drains `main`.
- Throughput: one word per cycle sustained when `ready_i = 1`.
- `ready_o` drops to 0 the cycle after the second word is captured without an `out_fire`. It returns to 1 the cycle after the draining `out_fire`.
- Simultaneous `in_fire` and `out_fire` in ONE keeps `count_o = 1`.
- No combinational path exists from `v_i`/`data_i`/`ready_i` to any output.

## Test plan
- **Reset:** assert `reset_i` asynchronously between edges while in FULL (`data_o = 0xA5…A5`) → all outputs go to reset values immediately (`v_o = 0`, `data_o = 0`, `count_o = 0`, `ready_o = 1`) without a clock edge. After release, inject `0x1` → `data_o = 0x1` after one edge.
- **Streaming:** `ready_i = 1`, inject 0,1,2,…,15 on consecutive cycles → `data_o` shows 0..15 one cycle delayed, `count_o = 1` throughout, `ready_o` never drops.
- **Back-pressure fill:** `ready_i = 0`, inject `0x11`, `0x22`, `0x33` with `v_i` held → `count_o` goes 1 then 2, `ready_o = 0` after `0x22`, and `0x33` is held at the input. Raise `ready_i` → output order is `0x11`, `0x22`, `0x33` with no loss.
- **FULL drain:** from FULL (`0x11`/`0x22`), one `out_fire` with `v_i = 0` → next cycle `data_o = 0x22`, `count_o = 1`, `ready_o = 1`.
- **Random stress:** random `v_i`/`ready_i` at 50% for 10k cycles with a scoreboard → output order matches input order and handshake rules hold. Additionally:
  - `v_o` never deasserts without an `out_fire`.
  - `data_o` is stable while `v_o & ~ready_i`.
  - `count_o` never exceeds 2.
- **Width check:** instantiate with `width_p = 1` and `width_p = 128`, send all-ones then alternating `0x5…5`/`0xA…A` → output is bit-exact.
